sprite_mover: RTL and testbench

SPRITE_MOVER -- requirements
Module: sprite_mover

---
 rtl/sprite_mover_if.sv | 21 ++
 rtl/sprite_mover.sv | 126 ++++++++++++
 tb/tb_sprite_mover.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_mover_if.sv
// sprite_mover_if: pixel, frame-control, bitmap ROM and palette signals of the sprite mover
interface sprite_mover_if #(parameter int IDX_W = 2, parameter int AW = 10);
  logic [15:0] i_x, i_y;
  logic i_v_sync, i_enable, i_respawn;
  logic [1:0] i_mode;
  logic signed [7:0] i_vel_x, i_vel_y;
  logic [AW-1:0] o_rom_addr;
  logic [IDX_W-1:0] i_rom_data;
  logic i_pal_we;
  logic [IDX_W-1:0] i_pal_addr;
  logic [23:0] i_pal_data;
  logic [7:0] o_red, o_green, o_blue;
  logic o_sprite_hit;
  logic signed [15:0] o_pos_x, o_pos_y;
  modport master (output i_x, i_y, i_v_sync, i_enable, i_respawn, i_mode, i_vel_x, i_vel_y, i_rom_data,
                  i_pal_we, i_pal_addr, i_pal_data,
                  input o_rom_addr, o_red, o_green, o_blue, o_sprite_hit, o_pos_x, o_pos_y);
  modport slave (input i_x, i_y, i_v_sync, i_enable, i_respawn, i_mode, i_vel_x, i_vel_y, i_rom_data,
                 i_pal_we, i_pal_addr, i_pal_data,
                 output o_rom_addr, o_red, o_green, o_blue, o_sprite_hit, o_pos_x, o_pos_y);
endinterface

// File: rtl/sprite_mover.sv
// sprite_mover: frame-stepped sprite motion (wrap/bounce/respawn) with a 2-stage bitmap+palette pixel pipeline
module sprite_mover #(
  parameter int SPR_W = 32, SPR_H = 32, SCALE_LOG2 = 2, IDX_W = 2,
  parameter int START_X = 276, START_Y = 96, SCREEN_W = 640, SCREEN_H = 480, HIDE_FRAMES = 2
) (
  input logic i_clk,
  input logic i_rst_n,
  sprite_mover_if.slave bus
);
  localparam int EXT_W = SPR_W << SCALE_LOG2;
  localparam int EXT_H = SPR_H << SCALE_LOG2;
  localparam int PAL_SIZE = 2 ** IDX_W;
  localparam int AW = $clog2(SPR_W * SPR_H);
  localparam int HW = HIDE_FRAMES > 0 ? $clog2(HIDE_FRAMES + 1) : 1;
  localparam logic signed [15:0] SX = 16'(START_X), SY = 16'(START_Y);
  localparam logic signed [15:0] MAX_X = 16'(SCREEN_W - EXT_W), MAX_Y = 16'(SCREEN_H - EXT_H);
  localparam logic signed [15:0] LIM_W = 16'(SCREEN_W), LIM_H = 16'(SCREEN_H);
  localparam logic signed [15:0] MIN_X = 16'(-EXT_W), MIN_Y = 16'(-EXT_H);
  localparam logic signed [16:0] EXT_W17 = 17'(EXT_W), EXT_H17 = 17'(EXT_H);
  typedef enum logic [1:0] {IDLE, ACTIVE, HIDDEN} state_t;
  state_t state, state_n;
  logic signed [15:0] pos_x, pos_y, pos_x_n, pos_y_n, sum_x, sum_y;
  logic signed [7:0] vel_x, vel_y, vel_x_n, vel_y_n;
  logic [HW-1:0] hide, hide_n;
  logic vs_prev, tick, respawn, hit1, hit_q;
  logic signed [16:0] dx, dy;
  logic [15:0] rx, ry;
  logic [31:0] addr;
  logic [23:0] pal [PAL_SIZE];
  function automatic logic signed [7:0] neg(input logic signed [7:0] v);
    return v == 8'sh80 ? 8'sd127 : -v;
  endfunction
  assign tick = bus.i_v_sync & ~vs_prev;
  assign bus.o_pos_x = pos_x;
  assign bus.o_pos_y = pos_y;
  always_comb begin
    state_n = state;
    pos_x_n = pos_x;
    pos_y_n = pos_y;
    vel_x_n = vel_x;
    vel_y_n = vel_y;
    hide_n = hide;
    respawn = 1'b0;
    sum_x = pos_x + {{8{vel_x[7]}}, vel_x};
    sum_y = pos_y + {{8{vel_y[7]}}, vel_y};
    if (!bus.i_enable) state_n = IDLE;
    else if (state == IDLE) begin
      if (bus.i_respawn) begin
        pos_x_n = SX;
        pos_y_n = SY;
      end else begin
        state_n = ACTIVE;
        vel_x_n = bus.i_vel_x;
        vel_y_n = bus.i_vel_y;
      end
    end else if (bus.i_respawn) respawn = 1'b1;
    else if (tick && state == HIDDEN) begin
      hide_n = hide - HW'(1);
      state_n = hide == HW'(1) ? ACTIVE : HIDDEN;
    end else if (tick && bus.i_mode == 2'd1) begin
      if (sum_x <= MIN_X || sum_x >= LIM_W || sum_y <= MIN_Y || sum_y >= LIM_H) respawn = 1'b1;
      else begin
        pos_x_n = sum_x;
        pos_y_n = sum_y;
      end
    end else if (tick && bus.i_mode == 2'd2) begin
      pos_x_n = sum_x < 16'sd0 ? 16'sd0 : (sum_x > MAX_X ? MAX_X : sum_x);
      pos_y_n = sum_y < 16'sd0 ? 16'sd0 : (sum_y > MAX_Y ? MAX_Y : sum_y);
      vel_x_n = (sum_x < 16'sd0 || sum_x > MAX_X) ? neg(vel_x) : vel_x;
      vel_y_n = (sum_y < 16'sd0 || sum_y > MAX_Y) ? neg(vel_y) : vel_y;
    end
    if (respawn) begin
      pos_x_n = SX;
      pos_y_n = SY;
      vel_x_n = bus.i_vel_x;
      vel_y_n = bus.i_vel_y;
      hide_n = HW'(HIDE_FRAMES);
      state_n = HIDE_FRAMES == 0 ? ACTIVE : HIDDEN;
    end
  end
  // Offsets are taken in 17 bits so the signed range test cannot overflow.
  always_comb begin
    dx = {bus.i_x[15], bus.i_x} - {pos_x[15], pos_x};
    dy = {bus.i_y[15], bus.i_y} - {pos_y[15], pos_y};
    rx = dx[15:0] >> SCALE_LOG2;
    ry = dy[15:0] >> SCALE_LOG2;
    addr = 32'(ry) * 32'(SPR_W) + 32'(rx);
    hit1 = dx >= 17'sd0 && dx < EXT_W17 && dy >= 17'sd0 && dy < EXT_H17 && state == ACTIVE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      pos_x <= SX;
      pos_y <= SY;
      vel_x <= '0;
      vel_y <= '0;
      hide <= '0;
      vs_prev <= 1'b1;
    end else begin
      state <= state_n;
      pos_x <= pos_x_n;
      pos_y <= pos_y_n;
      vel_x <= vel_x_n;
      vel_y <= vel_y_n;
      hide <= hide_n;
      vs_prev <= bus.i_v_sync;
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      hit_q <= 1'b0;
      bus.o_rom_addr <= '0;
      bus.o_red <= '0;
      bus.o_green <= '0;
      bus.o_blue <= '0;
      bus.o_sprite_hit <= 1'b0;
      for (int i = 0; i < PAL_SIZE; i++) pal[i] <= '0;
    end else begin
      hit_q <= hit1;
      bus.o_rom_addr <= addr[AW-1:0];
      bus.o_red <= hit_q ? pal[bus.i_rom_data][23:16] : 8'd0;
      bus.o_green <= hit_q ? pal[bus.i_rom_data][15:8] : 8'd0;
      bus.o_blue <= hit_q ? pal[bus.i_rom_data][7:0] : 8'd0;
      bus.o_sprite_hit <= hit_q && |bus.i_rom_data;
      if (bus.i_pal_we) pal[bus.i_pal_addr] <= bus.i_pal_data;
    end
endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: vector table, directed corner sequences and random stimulus against a behavioural model
module tb_sprite_mover;
  localparam int SPR_W = 32, SPR_H = 32, SL = 2, EXT_W = 128, EXT_H = 128;
  localparam int START_X = 276, START_Y = 96, SW = 640, SH = 480, HIDE = 2, AW = 10;
  logic clk = 0, rst_n = 0;
  logic [1:0] rom [SPR_W*SPR_H];
  sprite_mover_if #(.IDX_W(2), .AW(AW)) bus();
  assign bus.i_rom_data = rom[bus.o_rom_addr];
  sprite_mover dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {int mode, vx, vy, ticks, ex, ey;} vec_t;
  vec_t tbl[10];
  int checks = 0, errors = 0;
  int ms, mx, my, mvx, mvy, mhc, p_idx, e_r, e_g, e_b;
  bit mvs, p_hit, e_hit;
  logic [23:0] mpal [4];
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, got, exp);
    end
  endtask
  function automatic int neg8(input int v);
    return v == -128 ? 127 : -v;
  endfunction
  function automatic void m_reset();
    ms = 0; mx = START_X; my = START_Y; mvx = 0; mvy = 0; mhc = 0; mvs = 1;
    p_hit = 0; p_idx = 0; e_hit = 0; e_r = 0; e_g = 0; e_b = 0;
    for (int i = 0; i < 4; i++) mpal[i] = '0;
  endfunction
  function automatic void m_respawn(input int vx, input int vy);
    mx = START_X; my = START_Y; mvx = vx; mvy = vy; mhc = HIDE;
    ms = HIDE == 0 ? 1 : 2;
  endfunction
  function automatic void m_step();
    int xs, ys, vx, vy, nx, ny;
    bit hit, tick;
    logic [23:0] c;
    c = mpal[p_idx];
    e_hit = p_hit && p_idx != 0;
    e_r = p_hit ? int'(c[23:16]) : 0;
    e_g = p_hit ? int'(c[15:8]) : 0;
    e_b = p_hit ? int'(c[7:0]) : 0;
    xs = int'($signed(bus.i_x));
    ys = int'($signed(bus.i_y));
    hit = ms == 1 && xs >= mx && xs < mx + EXT_W && ys >= my && ys < my + EXT_H;
    p_hit = hit;
    p_idx = hit ? int'(rom[((ys - my) >> SL) * SPR_W + ((xs - mx) >> SL)]) : 0;
    if (bus.i_pal_we) mpal[bus.i_pal_addr] = bus.i_pal_data;
    tick = bus.i_v_sync && !mvs;
    mvs = bus.i_v_sync;
    vx = int'(bus.i_vel_x);
    vy = int'(bus.i_vel_y);
    if (!bus.i_enable) ms = 0;
    else if (ms == 0) begin
      if (bus.i_respawn) begin mx = START_X; my = START_Y; end
      else begin ms = 1; mvx = vx; mvy = vy; end
    end else if (bus.i_respawn) m_respawn(vx, vy);
    else if (tick && ms == 2) begin
      mhc--;
      if (mhc == 0) ms = 1;
    end else if (tick && bus.i_mode == 1) begin
      nx = mx + mvx; ny = my + mvy;
      if (nx <= -EXT_W || nx >= SW || ny <= -EXT_H || ny >= SH) m_respawn(vx, vy);
      else begin mx = nx; my = ny; end
    end else if (tick && bus.i_mode == 2) begin
      nx = mx + mvx; ny = my + mvy;
      if (nx < 0) begin mx = 0; mvx = neg8(mvx); end
      else if (nx > SW - EXT_W) begin mx = SW - EXT_W; mvx = neg8(mvx); end
      else mx = nx;
      if (ny < 0) begin my = 0; mvy = neg8(mvy); end
      else if (ny > SH - EXT_H) begin my = SH - EXT_H; mvy = neg8(mvy); end
      else my = ny;
    end
  endfunction
  task automatic compare_all();
    chk("pos_x", int'(bus.o_pos_x), mx);
    chk("pos_y", int'(bus.o_pos_y), my);
    chk("hit", int'(bus.o_sprite_hit), int'(e_hit));
    chk("red", int'(bus.o_red), e_r);
    chk("green", int'(bus.o_green), e_g);
    chk("blue", int'(bus.o_blue), e_b);
  endtask
  task automatic step();
    if (!rst_n) m_reset();
    else m_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask
  task automatic frame();
    bus.i_v_sync = 1; step();
    bus.i_v_sync = 0; step(); step();
  endtask
  task automatic restart();
    rst_n = 0;
    bus.i_enable = 0; bus.i_mode = 0; bus.i_vel_x = 0; bus.i_vel_y = 0; bus.i_respawn = 0;
    bus.i_v_sync = 0; bus.i_pal_we = 0; bus.i_pal_addr = 0; bus.i_pal_data = 0;
    bus.i_x = 16'hC000; bus.i_y = 16'hC000;
    step();
    rst_n = 1;
    step();
  endtask
  task automatic pal_wr(input int a, input logic [23:0] d);
    bus.i_pal_we = 1; bus.i_pal_addr = 2'(a); bus.i_pal_data = d;
    step();
    bus.i_pal_we = 0;
  endtask
  task automatic go(input int mode, input int vx, input int vy);
    bus.i_enable = 1; bus.i_mode = 2'(mode); bus.i_vel_x = 8'(vx); bus.i_vel_y = 8'(vy);
    step();
  endtask
  initial begin
    for (int i = 0; i < SPR_W * SPR_H; i++) rom[i] = 2'($urandom_range(0, 3));
    rom[0] = 2'd1;
    tbl[0] = '{1, -1, 1, 5, 271, 101};
    tbl[1] = '{0, 5, 5, 3, 276, 96};
    tbl[2] = '{3, 5, 5, 3, 276, 96};
    tbl[3] = '{2, 5, 0, 48, 512, 96};
    tbl[4] = '{2, 5, 0, 49, 507, 96};
    tbl[5] = '{2, -128, 0, 4, 127, 96};
    tbl[6] = '{2, 0, -128, 2, 276, 127};
    tbl[7] = '{1, -100, 0, 4, -124, 96};
    tbl[8] = '{1, -100, 0, 5, 276, 96};
    tbl[9] = '{2, 0, 127, 3, 276, 352};
    restart();
    chk("rst_pos_x", int'(bus.o_pos_x), 276);
    chk("rst_pos_y", int'(bus.o_pos_y), 96);
    chk("rst_red", int'(bus.o_red), 0);
    foreach (tbl[k]) begin
      restart();
      go(tbl[k].mode, tbl[k].vx, tbl[k].vy);
      for (int t = 0; t < tbl[k].ticks; t++) frame();
      chk($sformatf("tbl%0d_x", k), int'(bus.o_pos_x), tbl[k].ex);
      chk($sformatf("tbl%0d_y", k), int'(bus.o_pos_y), tbl[k].ey);
    end
    // wrap exit at the bottom edge, hidden frames, then visible at spawn
    restart();
    pal_wr(1, 24'h9AD2FF);
    go(1, 0, 8);
    for (int t = 0; t < 47; t++) frame();
    chk("wrap_pre_y", int'(bus.o_pos_y), 472);
    bus.i_x = 16'd276; bus.i_y = 16'd96;
    frame();
    chk("wrap_resp_y", int'(bus.o_pos_y), 96);
    frame();
    chk("hidden_hit", int'(bus.o_sprite_hit), 0);
    frame();
    chk("unhide_hit", int'(bus.o_sprite_hit), 1);
    chk("unhide_red", int'(bus.o_red), 8'h9A);
    // palette colour exactly two cycles after the coordinate, then write-after-read ordering
    restart();
    pal_wr(1, 24'h9AD2FF);
    go(0, 0, 0);
    step();
    bus.i_x = 16'd276; bus.i_y = 16'd96;
    step();
    chk("lat1_hit", int'(bus.o_sprite_hit), 0);
    step();
    chk("lat2_hit", int'(bus.o_sprite_hit), 1);
    chk("lat2_red", int'(bus.o_red), 8'h9A);
    chk("lat2_green", int'(bus.o_green), 8'hD2);
    chk("lat2_blue", int'(bus.o_blue), 8'hFF);
    pal_wr(1, 24'h112233);
    chk("pal_old_red", int'(bus.o_red), 8'h9A);
    step();
    chk("pal_new_red", int'(bus.o_red), 8'h11);
    // respawn coincident with a frame tick
    restart();
    pal_wr(1, 24'h010203);
    go(1, 3, 3);
    frame(); frame();
    chk("pre_resp_x", int'(bus.o_pos_x), 282);
    bus.i_x = 16'd276; bus.i_y = 16'd96;
    bus.i_v_sync = 1; bus.i_respawn = 1;
    step();
    bus.i_respawn = 0; bus.i_v_sync = 0;
    chk("resp_tick_x", int'(bus.o_pos_x), 276);
    step(); step();
    chk("resp_hidden_hit", int'(bus.o_sprite_hit), 0);
    frame(); frame();
    chk("hidden_nomove_x", int'(bus.o_pos_x), 276);
    frame();
    chk("resume_x", int'(bus.o_pos_x), 279);
    // asynchronous reset mid-frame, released with v_sync high
    restart();
    pal_wr(1, 24'hABCDEF);
    go(1, 2, 2);
    frame(); frame();
    bus.i_x = 16'd280; bus.i_y = 16'd100;
    step(); step();
    chk("pre_rst_hit", int'(bus.o_sprite_hit), 1);
    bus.i_v_sync = 1;
    #2 rst_n = 0;
    #1;
    chk("async_hit", int'(bus.o_sprite_hit), 0);
    chk("async_red", int'(bus.o_red), 0);
    chk("async_x", int'(bus.o_pos_x), 276);
    chk("async_y", int'(bus.o_pos_y), 96);
    step();
    rst_n = 1;
    for (int t = 0; t < 5; t++) step();
    chk("no_spur_x", int'(bus.o_pos_x), 276);
    // randomized traffic against the model
    restart();
    for (int c = 0; c < 3000; c++) begin
      bus.i_v_sync = $urandom_range(0, 7) == 0;
      bus.i_enable = $urandom_range(0, 31) != 0;
      if ($urandom_range(0, 63) == 0) bus.i_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) begin
        bus.i_vel_x = 8'($urandom);
        bus.i_vel_y = 8'($urandom);
      end
      bus.i_respawn = $urandom_range(0, 99) == 0;
      bus.i_pal_we = $urandom_range(0, 7) == 0;
      bus.i_pal_addr = 2'($urandom_range(0, 3));
      bus.i_pal_data = 24'($urandom);
      bus.i_x = 16'(mx - 8 + int'($urandom_range(0, EXT_W + 16)));
      bus.i_y = 16'(my - 8 + int'($urandom_range(0, EXT_H + 16)));
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
